pcie_link_pm_ctrl: RTL and testbench

PCIE_LINK_PM_CTRL -- requirements
Module: pcie_link_pm_ctrl
Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  NUM_FUNC, 8, physical functions tracked
  CNT_W, 16, idle counter and threshold width
  ACK_TIMEOUT, 4096, max cycles waiting for pm_ack / pm_exit_done
REQ-002 Ports SHALL be (name direction width meaning); one clock; reset asynchronous, active-low:
  clk_sys  in  1  system clock
  rst_n_sys  in  1  async active-low reset
  link_up  in  1  DLL link-up status
  tx_activity  in  1  TLP/DLLP pending or in flight on TX
  rx_activity  in  1  receive activity
  aspm_en  in  2  bit0 L0s enable, bit1 L1 enable
  l0s_idle_thr  in  CNT_W  idle cycles before L0s entry; 0 = never
  l1_idle_thr  in  CNT_W  idle cycles before L1 entry; 0 = never
  fn_dstate_req  in  2*NUM_FUNC  per-function requested D-state (00 D0, 01 D1, 10 D2, 11 D3hot)
  fn_dstate  out  2*NUM_FUNC  per-function current D-state
  wake_req  in  NUM_FUNC  per-function wake/PME request
  pme_clr  in  NUM_FUNC  per-function PME status clear
  pme_status  out  NUM_FUNC  sticky PME status
  pm_req_valid  out  1  entry request to PHY, level
  pm_req_state  out  2  requested state (01 L0s, 10 L1), stable while pm_req_valid
  pm_ack  in  1  PHY confirms entry
  pm_exit_req  out  1  exit request to PHY, level
  pm_exit_done  in  1  PHY back in L0
  link_pm_state  out  3  0 LINK_DOWN, 1 L0, 2 L0S_REQ, 3 L0S, 4 L1_REQ, 5 L1, 6 EXIT
  pm_timeout_err  out  1  one-cycle pulse on handshake timeout
Function
REQ-003 Idle counter SHALL increment each cycle in L0 with link_up=1 and tx_activity=rx_activity=0, saturate at 2^CNT_W-1, and clear on any activity or when leaving L0.
REQ-004 L1 eligibility SHALL be idle_cnt >= l1_idle_thr, l1_idle_thr != 0, and (aspm_en[1]=1 or every fn_dstate != D0); L0s eligibility SHALL be aspm_en[0]=1, l0s_idle_thr != 0, idle_cnt >= l0s_idle_thr.
REQ-005 From L0, the FSM SHALL move to L1_REQ if L1-eligible, else to L0S_REQ if L0s-eligible, on the next edge; L1 SHALL win when both are eligible.
REQ-006 In L0S_REQ/L1_REQ, pm_req_valid SHALL be 1 with pm_req_state = 01/10; on pm_ack the FSM SHALL enter L0S/L1 next cycle; activity in a REQ state SHALL NOT withdraw the request.
REQ-007 In L0S, tx_activity or rx_activity SHALL move the FSM to EXIT; in L1, activity or any wake_req bit SHALL move it to EXIT.
REQ-008 In EXIT, pm_exit_req SHALL be 1 until pm_exit_done, then the FSM SHALL enter L0 with idle_cnt=0.
REQ-009 A single wait counter SHALL run in REQ and EXIT states; reaching ACK_TIMEOUT cycles without ack/done SHALL pulse pm_timeout_err for one cycle and force L0.
REQ-010 link_up=0 SHALL force LINK_DOWN next cycle from any state, deasserting pm_req_valid and pm_exit_req; link_up=1 in LINK_DOWN SHALL enter L0.
REQ-011 fn_dstate[i] SHALL take fn_dstate_req[i] one cycle later, only while link_pm_state is L0 or LINK_DOWN; requests to D1 or D2 from a higher-numbered non-D0 state (D2->D1, D3hot->D1, D3hot->D2) SHALL be ignored.
REQ-012 pme_status[i] SHALL set when wake_req[i]=1 and fn_dstate[i] != D0, clear on pme_clr[i]; simultaneous set and clear SHALL leave it set.
Reset
REQ-013 On rst_n_sys=0 (asynchronous, mid-handshake included): state LINK_DOWN, fn_dstate all D0, pme_status 0, counters 0, all other outputs 0.
Verification
REQ-014 link_up=1, aspm_en=01, l0s_idle_thr=10, no activity -> L0S_REQ after 10 idle cycles; pm_ack -> L0S; tx_activity -> EXIT; pm_exit_done -> L0.
REQ-015 aspm_en=11, l0s_idle_thr=l1_idle_thr=5 -> L1_REQ with pm_req_state=10, never L0S_REQ.
REQ-016 L0S_REQ with pm_ack held 0, ACK_TIMEOUT=16 -> pm_timeout_err pulses once at cycle 16; state L0.
REQ-017 fn_dstate[0]=D3hot, fn_dstate_req[0]=D1 -> fn_dstate[0] stays D3hot; D0 request -> D0 next cycle.
REQ-018 In L1 with fn_dstate[3]=D3hot, wake_req[3]=1 and pme_clr[3]=1 together -> pme_status[3]=1, state EXIT; link_up=0 mid-EXIT -> LINK_DOWN, pm_exit_req=0.

---
 rtl/pcie_link_pm_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pcie_link_pm_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_link_pm_ctrl.sv
// PCIe link power-management controller: ASPM L0s/L1 entry on idle, exit on activity/wake,
// PHY handshake with timeout, per-function D-state tracking and sticky PME status.
module pcie_link_pm_ctrl #(
  parameter int unsigned NUM_FUNC    = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ACK_TIMEOUT = 4096
) (
  input  logic                  clk_sys,
  input  logic                  rst_n_sys,
  input  logic                  link_up,
  input  logic                  tx_activity,
  input  logic                  rx_activity,
  input  logic [1:0]            aspm_en,
  input  logic [CNT_W-1:0]      l0s_idle_thr,
  input  logic [CNT_W-1:0]      l1_idle_thr,
  input  logic [2*NUM_FUNC-1:0] fn_dstate_req,
  output logic [2*NUM_FUNC-1:0] fn_dstate,
  input  logic [NUM_FUNC-1:0]   wake_req,
  input  logic [NUM_FUNC-1:0]   pme_clr,
  output logic [NUM_FUNC-1:0]   pme_status,
  output logic                  pm_req_valid,
  output logic [1:0]            pm_req_state,
  input  logic                  pm_ack,
  output logic                  pm_exit_req,
  input  logic                  pm_exit_done,
  output logic [2:0]            link_pm_state,
  output logic                  pm_timeout_err
);

  localparam int unsigned WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_LINK_DOWN = 3'd0,
    ST_L0        = 3'd1,
    ST_L0S_REQ   = 3'd2,
    ST_L0S       = 3'd3,
    ST_L1_REQ    = 3'd4,
    ST_L1        = 3'd5,
    ST_EXIT      = 3'd6
  } state_e;

  localparam logic [1:0] D0 = 2'b00;
  localparam logic [1:0] D1 = 2'b01;
  localparam logic [1:0] D2 = 2'b10;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        idle_q, idle_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic                    err_q, err_d;
  logic [2*NUM_FUNC-1:0]   dstate_q, dstate_d;
  logic [NUM_FUNC-1:0]     pme_q, pme_d;

  logic activity;
  logic all_non_d0;
  logic l1_ok;
  logic l0s_ok;
  logic expired;
  logic [NUM_FUNC-1:0] fn_low_power;

  // A function may not be promoted D2->D1, D3hot->D1 or D3hot->D2.
  function automatic logic dstate_req_allowed(input logic [1:0] cur, input logic [1:0] req);
    return !(((req == D1) || (req == D2)) && (cur != D0) && (req < cur));
  endfunction

  always_comb begin
    all_non_d0   = 1'b1;
    fn_low_power = '0;
    for (int unsigned i = 0; i < NUM_FUNC; i++) begin
      fn_low_power[i] = (dstate_q[2*i +: 2] != D0);
      if (!fn_low_power[i]) all_non_d0 = 1'b0;
    end
  end

  assign activity = tx_activity | rx_activity;
  assign l1_ok    = (l1_idle_thr != '0) && (idle_q >= l1_idle_thr) && (aspm_en[1] || all_non_d0);
  assign l0s_ok   = aspm_en[0] && (l0s_idle_thr != '0) && (idle_q >= l0s_idle_thr);
  assign expired  = (wait_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    if (!link_up) begin
      state_d = ST_LINK_DOWN;
    end else begin
      unique case (state_q)
        ST_LINK_DOWN: state_d = ST_L0;
        ST_L0: begin
          if (l1_ok)       state_d = ST_L1_REQ;
          else if (l0s_ok) state_d = ST_L0S_REQ;
        end
        ST_L0S_REQ, ST_L1_REQ: begin
          if (pm_ack) begin
            state_d = (state_q == ST_L0S_REQ) ? ST_L0S : ST_L1;
          end else if (expired) begin
            state_d = ST_L0;
            err_d   = 1'b1;
          end
        end
        ST_L0S: if (activity) state_d = ST_EXIT;
        ST_L1:  if (activity || (wake_req != '0)) state_d = ST_EXIT;
        ST_EXIT: begin
          if (pm_exit_done) begin
            state_d = ST_L0;
          end else if (expired) begin
            state_d = ST_L0;
            err_d   = 1'b1;
          end
        end
        default: state_d = ST_LINK_DOWN;
      endcase
    end
  end

  // Shared handshake wait counter restarts on every state change.
  always_comb begin
    wait_d = '0;
    if ((state_d == state_q) &&
        ((state_q == ST_L0S_REQ) || (state_q == ST_L1_REQ) || (state_q == ST_EXIT)))
      wait_d = wait_q + 1'b1;
  end

  always_comb begin
    idle_d = '0;
    if ((state_q == ST_L0) && (state_d == ST_L0) && !activity)
      idle_d = (idle_q == '1) ? idle_q : idle_q + 1'b1;
  end

  always_comb begin
    dstate_d = dstate_q;
    if ((state_q == ST_LINK_DOWN) || (state_q == ST_L0)) begin
      for (int unsigned i = 0; i < NUM_FUNC; i++) begin
        if (dstate_req_allowed(dstate_q[2*i +: 2], fn_dstate_req[2*i +: 2]))
          dstate_d[2*i +: 2] = fn_dstate_req[2*i +: 2];
      end
    end
  end

  // Set wins over clear when both arrive together.
  assign pme_d = (wake_req & fn_low_power) | (pme_q & ~pme_clr);

  always_ff @(posedge clk_sys or negedge rst_n_sys) begin
    if (!rst_n_sys) begin
      state_q  <= ST_LINK_DOWN;
      idle_q   <= '0;
      wait_q   <= '0;
      err_q    <= 1'b0;
      dstate_q <= '0;
      pme_q    <= '0;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
      dstate_q <= dstate_d;
      pme_q    <= pme_d;
    end
  end

  always_comb begin
    pm_req_valid  = (state_q == ST_L0S_REQ) || (state_q == ST_L1_REQ);
    pm_req_state  = 2'b00;
    if (state_q == ST_L0S_REQ) pm_req_state = 2'b01;
    if (state_q == ST_L1_REQ)  pm_req_state = 2'b10;
    pm_exit_req    = (state_q == ST_EXIT);
    link_pm_state  = state_q;
    pm_timeout_err = err_q;
    fn_dstate      = dstate_q;
    pme_status     = pme_q;
  end

endmodule

// File: tb/tb_pcie_link_pm_ctrl.sv
// Self-checking bench for pcie_link_pm_ctrl: directed scenarios then randomized traffic,
// all compared each cycle against a behavioural model of the link PM rules.
module tb_pcie_link_pm_ctrl;

  localparam int NF = 8;
  localparam int CW = 6;
  localparam int TO = 16;

  logic              clk_sys = 1'b0;
  logic              rst_n_sys;
  logic              link_up;
  logic              tx_activity;
  logic              rx_activity;
  logic [1:0]        aspm_en;
  logic [CW-1:0]     l0s_idle_thr;
  logic [CW-1:0]     l1_idle_thr;
  logic [2*NF-1:0]   fn_dstate_req;
  logic [2*NF-1:0]   fn_dstate;
  logic [NF-1:0]     wake_req;
  logic [NF-1:0]     pme_clr;
  logic [NF-1:0]     pme_status;
  logic              pm_req_valid;
  logic [1:0]        pm_req_state;
  logic              pm_ack;
  logic              pm_exit_req;
  logic              pm_exit_done;
  logic [2:0]        link_pm_state;
  logic              pm_timeout_err;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state; link states numbered as the link_pm_state output.
  int m_state;
  int m_idle;
  int m_wait;
  bit m_err;
  int m_ds[NF];
  bit m_pme[NF];

  pcie_link_pm_ctrl #(
    .NUM_FUNC   (NF),
    .CNT_W      (CW),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk_sys       (clk_sys),
    .rst_n_sys     (rst_n_sys),
    .link_up       (link_up),
    .tx_activity   (tx_activity),
    .rx_activity   (rx_activity),
    .aspm_en       (aspm_en),
    .l0s_idle_thr  (l0s_idle_thr),
    .l1_idle_thr   (l1_idle_thr),
    .fn_dstate_req (fn_dstate_req),
    .fn_dstate     (fn_dstate),
    .wake_req      (wake_req),
    .pme_clr       (pme_clr),
    .pme_status    (pme_status),
    .pm_req_valid  (pm_req_valid),
    .pm_req_state  (pm_req_state),
    .pm_ack        (pm_ack),
    .pm_exit_req   (pm_exit_req),
    .pm_exit_done  (pm_exit_done),
    .link_pm_state (link_pm_state),
    .pm_timeout_err(pm_timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_idle  = 0;
    m_wait  = 0;
    m_err   = 0;
    for (int i = 0; i < NF; i++) begin
      m_ds[i]  = 0;
      m_pme[i] = 0;
    end
  endtask

  task automatic model_step();
    int  nxt;
    bit  act;
    bit  tmo;
    bit  all_lp;
    int  r;
    act = tx_activity || rx_activity;
    nxt = m_state;
    tmo = 0;
    all_lp = 1;
    for (int i = 0; i < NF; i++) if (m_ds[i] == 0) all_lp = 0;
    if (!link_up) nxt = 0;
    else begin
      case (m_state)
        0: nxt = 1;
        1: begin
          if (l1_idle_thr != 0 && m_idle >= int'(l1_idle_thr) && (aspm_en[1] || all_lp)) nxt = 4;
          else if (aspm_en[0] && l0s_idle_thr != 0 && m_idle >= int'(l0s_idle_thr)) nxt = 2;
        end
        2, 4: begin
          if (pm_ack) nxt = m_state + 1;
          else if (m_wait + 1 >= TO) begin nxt = 1; tmo = 1; end
        end
        3: if (act) nxt = 6;
        5: if (act || wake_req != 0) nxt = 6;
        6: begin
          if (pm_exit_done) nxt = 1;
          else if (m_wait + 1 >= TO) begin nxt = 1; tmo = 1; end
        end
        default: nxt = 0;
      endcase
    end
    for (int i = 0; i < NF; i++)
      m_pme[i] = (wake_req[i] && m_ds[i] != 0) || (m_pme[i] && !pme_clr[i]);
    if (m_state == 0 || m_state == 1) begin
      for (int i = 0; i < NF; i++) begin
        r = int'(fn_dstate_req[2*i +: 2]);
        if (!((r == 1 || r == 2) && m_ds[i] > r)) m_ds[i] = r;
      end
    end
    if (m_state == 1 && nxt == 1 && !act) m_idle = (m_idle + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_idle + 1;
    else m_idle = 0;
    if (nxt == m_state && (m_state == 2 || m_state == 4 || m_state == 6)) m_wait = m_wait + 1;
    else m_wait = 0;
    m_err   = tmo;
    m_state = nxt;
  endtask

  task automatic compare_all();
    logic [2*NF-1:0] eds;
    logic [NF-1:0]   epme;
    for (int i = 0; i < NF; i++) begin
      eds[2*i +: 2] = 2'(m_ds[i]);
      epme[i]       = m_pme[i];
    end
    chk("link_pm_state", 64'(link_pm_state), 64'(m_state));
    chk("pm_req_valid", 64'(pm_req_valid), 64'(m_state == 2 || m_state == 4));
    chk("pm_req_state", 64'(pm_req_state), 64'((m_state == 2) ? 1 : (m_state == 4) ? 2 : 0));
    chk("pm_exit_req", 64'(pm_exit_req), 64'(m_state == 6));
    chk("pm_timeout_err", 64'(pm_timeout_err), 64'(m_err));
    chk("fn_dstate", 64'(fn_dstate), 64'(eds));
    chk("pme_status", 64'(pme_status), 64'(epme));
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run_until(input int target, input int limit, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (int'(link_pm_state) != target && cycles < limit);
  endtask

  initial begin
    int c;
    bit saw_l0s;
    int ackp;
    int donep;

    rst_n_sys     = 1'b0;
    link_up       = 1'b0;
    tx_activity   = 1'b0;
    rx_activity   = 1'b0;
    aspm_en       = 2'b00;
    l0s_idle_thr  = '0;
    l1_idle_thr   = '0;
    fn_dstate_req = '0;
    wake_req      = '0;
    pme_clr       = '0;
    pm_ack        = 1'b0;
    pm_exit_done  = 1'b0;
    model_reset();

    #3;
    compare_all();
    chk("reset_state", 64'(link_pm_state), 64'd0);
    @(negedge clk_sys);
    rst_n_sys = 1'b1;
    tick();
    chk("down_holds", 64'(link_pm_state), 64'd0);

    // L0s entry after threshold idle cycles, ack, exit on tx activity
    link_up = 1'b1; aspm_en = 2'b01; l0s_idle_thr = 6'd10;
    tick();
    chk("l0_entry", 64'(link_pm_state), 64'd1);
    run_until(2, 40, c);
    chk("l0s_req_latency", 64'(c), 64'd11);
    chk("l0s_req_state", 64'(pm_req_state), 64'd1);
    tx_activity = 1'b1;
    tick();
    chk("req_not_withdrawn", 64'(pm_req_valid), 64'd1);
    tx_activity = 1'b0; pm_ack = 1'b1;
    tick();
    chk("l0s_entered", 64'(link_pm_state), 64'd3);
    pm_ack = 1'b0;
    tick();
    tx_activity = 1'b1;
    tick();
    chk("l0s_exit", 64'(link_pm_state), 64'd6);
    chk("exit_req", 64'(pm_exit_req), 64'd1);
    tx_activity = 1'b0;
    tick();
    pm_exit_done = 1'b1;
    tick();
    chk("exit_to_l0", 64'(link_pm_state), 64'd1);
    pm_exit_done = 1'b0;

    // L1 beats L0s at equal thresholds; function 3 goes to D3hot on the way
    aspm_en = 2'b11; l0s_idle_thr = 6'd5; l1_idle_thr = 6'd5; fn_dstate_req = 16'h00C0;
    c = 0; saw_l0s = 0;
    do begin
      tick();
      c++;
      if (link_pm_state == 3'd2) saw_l0s = 1;
    end while (link_pm_state != 3'd4 && c < 30);
    chk("l1_req_latency", 64'(c), 64'd6);
    chk("no_l0s_req", 64'(saw_l0s), 64'd0);
    chk("l1_req_state", 64'(pm_req_state), 64'd2);
    chk("fn3_d3hot", 64'(fn_dstate[7:6]), 64'd3);
    pm_ack = 1'b1;
    tick();
    chk("l1_entered", 64'(link_pm_state), 64'd5);
    pm_ack = 1'b0;
    tick();

    // Wake with simultaneous clear in L1, then link drop mid-exit
    wake_req = 8'h08; pme_clr = 8'h08;
    tick();
    chk("pme_set_wins", 64'(pme_status[3]), 64'd1);
    chk("wake_exit", 64'(link_pm_state), 64'd6);
    wake_req = '0; pme_clr = '0; link_up = 1'b0;
    tick();
    chk("exit_link_down", 64'(link_pm_state), 64'd0);
    chk("exit_req_dropped", 64'(pm_exit_req), 64'd0);
    pme_clr = 8'h08;
    tick();
    chk("pme_cleared", 64'(pme_status[3]), 64'd0);
    pme_clr = '0;

    // D-state promotion rules on function 0
    fn_dstate_req = 16'h00C3;
    tick();
    chk("fn0_d3hot", 64'(fn_dstate[1:0]), 64'd3);
    fn_dstate_req = 16'h00C1;
    tick();
    chk("fn0_d1_ignored", 64'(fn_dstate[1:0]), 64'd3);
    fn_dstate_req = 16'h00C2;
    tick();
    chk("fn0_d2_ignored", 64'(fn_dstate[1:0]), 64'd3);
    fn_dstate_req = 16'h00C0;
    tick();
    chk("fn0_d0", 64'(fn_dstate[1:0]), 64'd0);

    // L1 without ASPM L1 enable when every function is out of D0
    link_up = 1'b1; aspm_en = 2'b00; l0s_idle_thr = 6'd3; l1_idle_thr = 6'd3;
    fn_dstate_req = 16'h5555;
    tick();
    run_until(4, 20, c);
    chk("l1_by_dstate_latency", 64'(c), 64'd4);
    link_up = 1'b0;
    tick();
    chk("req_dropped", 64'(pm_req_valid), 64'd0);
    fn_dstate_req = '0;
    tick();

    // Handshake timeout
    link_up = 1'b1; aspm_en = 2'b01; l0s_idle_thr = 6'd2; l1_idle_thr = '0;
    tick();
    run_until(2, 20, c);
    chk("to_req_reached", 64'(link_pm_state), 64'd2);
    c = 0;
    do begin
      tick();
      c++;
    end while (!pm_timeout_err && c < 40);
    chk("timeout_latency", 64'(c), 64'd16);
    chk("timeout_to_l0", 64'(link_pm_state), 64'd1);
    tick();
    chk("timeout_single_pulse", 64'(pm_timeout_err), 64'd0);

    // Asynchronous reset in the middle of a request
    run_until(2, 20, c);
    #2;
    rst_n_sys = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("async_rst_state", 64'(link_pm_state), 64'd0);
    @(negedge clk_sys);
    rst_n_sys = 1'b1;
    tick();

    // Randomized traffic
    ackp = 50; donep = 50;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) begin
        aspm_en      = 2'($urandom_range(0, 3));
        l0s_idle_thr = ($urandom_range(0, 4) == 0) ? '0 : CW'($urandom_range(1, 12));
        l1_idle_thr  = ($urandom_range(0, 4) == 0) ? '0 : CW'($urandom_range(1, 20));
        case ($urandom_range(0, 3))
          0: ackp = 3;
          1: ackp = 20;
          2: ackp = 50;
          default: ackp = 90;
        endcase
        donep = ($urandom_range(0, 1) == 0) ? 4 : 40;
      end
      link_up      = ($urandom_range(0, 99) != 0);
      tx_activity  = ($urandom_range(0, 11) == 0);
      rx_activity  = ($urandom_range(0, 11) == 0);
      pm_ack       = ($urandom_range(0, 99) < ackp);
      pm_exit_done = ($urandom_range(0, 99) < donep);
      wake_req     = ($urandom_range(0, 15) == 0) ? NF'($urandom) : '0;
      pme_clr      = ($urandom_range(0, 15) == 0) ? NF'($urandom) : '0;
      if ($urandom_range(0, 19) == 0) fn_dstate_req = (2*NF)'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
